mem_bus_if: RTL and testbench
=============================

# mem_bus_if

Memory bus interface between the 6502 core and external memory/IO. Each core access (address, write data, read_en) is captured into held registers and launched as a request/acknowledge transaction on the memory side, with per-region setup wait states and an acknowledge timeout. While a transaction is in flight, the block holds `cpu_stall` to freeze the phase generator. On completion it returns read data to the core's `data_in`.

## Interface
Parameters:
- `WS_LO`, default 0: wait cycles before `mem_req` for addresses 0x0000–0x7FFF (0–15).
- `WS_HI`, default 1: wait cycles before `mem_req` for addresses 0x8000–0xFFFF (0–15).
- `TIMEOUT`, default 15: maximum ACCESS cycles without `mem_ack` before the transaction is aborted (1–255).

Ports:
- `ph2`  in  1  single clock; all flops update on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  16  core address.
- `cpu_wdata`  in  8  core write data.
- `cpu_read_en`  in  1  1 = read, 0 = write.
- `cpu_rdata`  out  8  read data to the core; held until the next read completes.
- `cpu_stall`  out  1  freezes the core's phase generator; driven directly from a flop.
- `mem_addr`  out  16  latched address.
- `mem_wdata`  out  8  latched write data.
- `mem_we`  out  1  latched write strobe qualifier.
- `mem_req`  out  1  request; high only in ACCESS.
- `mem_ack`  in  1  completion from memory; sampled only while `mem_req` = 1.
- `mem_rdata`  in  8  read data, valid in the `mem_ack` cycle.
- `bus_err`  out  1  sticky timeout flag.

## Operation
States: IDLE, WAIT, ACCESS, RESP.

- **IDLE:** on every edge, latch `cpu_addr`, `cpu_wdata` and `we = ~cpu_read_en`, and load the wait counter with the region count (decided by `cpu_addr[15]`).
  - Next state is WAIT if the count > 0, otherwise ACCESS.
  - `cpu_stall` goes high on this same edge.
- **WAIT:** decrement the wait counter each cycle. Go to ACCESS when it reaches 1→0. `mem_req` = 0.
- **ACCESS:** `mem_req` = 1. The timeout counter starts at 0 and increments each cycle.
  - `mem_ack` = 1 → RESP. On a read, `mem_rdata` is captured into `cpu_rdata`.
  - Counter reaching `TIMEOUT - 1` with no ack → RESP. On a read, `cpu_rdata` = 0xFF. `bus_err` is set.
  - Ack and timeout on the same edge: the ack wins, and `bus_err` is not set.
- **RESP:** one cycle, then → IDLE. `cpu_stall` drops on the RESP→IDLE edge.
- **Holding:** `mem_addr`, `mem_wdata` and `mem_we` hold their latched values in every non-IDLE state and keep their last values in IDLE.
- **Writes:** `cpu_rdata` is never modified by a write.
- **`bus_err`:** cleared only by reset.
- **Reset values:** state IDLE; `cpu_stall` 0; `mem_req` 0; `mem_we` 0; `mem_addr` 0x0000; `mem_wdata` 0x00; `cpu_rdata` 0x00; `bus_err` 0; both counters 0.
- **Reset mid-transaction:** asynchronous return to the reset values; `mem_req` falls without waiting for ph2.

## Timing
- **Zero-wait, immediate ack:** edge0 capture (IDLE→ACCESS), edge1 ack (→RESP, data captured), edge2 →IDLE. `cpu_stall` is high for 2 cycles.
- **General stall length:** `cpu_stall` high cycles = WS + ack_cycles + 1, where ack_cycles ≥ 1 is the number of ACCESS cycles.
- **Timeout case:** stall length = WS + `TIMEOUT` + 1.
- **`cpu_rdata` valid:** from the ACCESS→RESP edge onward, i.e. one cycle before `cpu_stall` falls.
- **Counter widths:** wait counter 4 bits; timeout counter 8 bits. Neither wraps, because the FSM leaves the state at terminal count.

## Structure
- Package `mem_bus_pkg` holds:
  - state enum `bus_state_t`;
  - `REGION_SPLIT` = 16'h8000;
  - `BUS_ERR_DATA` = 8'hFF.
- One sub-module, `bus_timeout_ctr`: an 8-bit loadable up-counter with clear, enable and terminal-count outputs.
- FSM, latches and wait counter live in `mem_bus_if`.

## Test plan
- Read 0x1234, `WS_LO` = 0, ack in the first ACCESS cycle with `mem_rdata` = 0xA5 → `mem_req` high 1 cycle, `cpu_stall` high 2 cycles, `cpu_rdata` = 0xA5, `bus_err` = 0.
- Write 0x3C to 0x9000, `WS_HI` = 1, ack after 3 cycles → `mem_req` rises 1 cycle after capture, `mem_we` = 1, `mem_wdata` = 0x3C, `cpu_rdata` unchanged, stall = 5 cycles.
- Read 0x0200, never acked, `TIMEOUT` = 15 → `mem_req` high exactly 15 cycles, `cpu_rdata` = 0xFF, `bus_err` = 1 and stays 1 across later good accesses.
- `mem_ack` pulsed during WAIT, then a legal ack in ACCESS → the WAIT ack is ignored and the transaction completes normally on the legal ack.
- Ack in the same cycle as timeout terminal count with `mem_rdata` = 0x42 → `cpu_rdata` = 0x42, `bus_err` = 0.
- Reset asserted mid-ACCESS between clock edges → `mem_req` and `cpu_stall` fall immediately, all outputs at reset values, and the next access after release is captured normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the 6502 memory bus interface.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } bus_state_t;

  // Addresses at or above this use the high-region wait count.
  localparam logic [15:0] REGION_SPLIT = 16'h8000;

  // Read data returned to the core when a transaction times out.
  localparam logic [7:0] BUS_ERR_DATA = 8'hFF;

  function automatic logic is_hi_region(input logic [15:0] addr);
    return addr >= REGION_SPLIT;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// 8-bit loadable up-counter with synchronous clear/enable and a terminal-count flag.
module bus_timeout_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic [7:0] term,
  output logic       tc
);

  logic [7:0] count_q;

  // Count register: clear beats load beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'h00;
    end else if (clr) begin
      count_q <= 8'h00;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= count_q + 8'h01;
    end
  end

  assign tc = (count_q == term);

endmodule

// File: rtl/mem_bus_if.sv
// Core-to-memory bus bridge: captures each core access, applies region wait states,
// runs a req/ack handshake with timeout, and stalls the core until it completes.
module mem_bus_if
  import mem_bus_pkg::*;
#(
  parameter int unsigned WS_LO   = 0,
  parameter int unsigned WS_HI   = 1,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        ph2,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_read_en,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err
);

  localparam logic [3:0] WsLoCnt = 4'(WS_LO);
  localparam logic [3:0] WsHiCnt = 4'(WS_HI);
  localparam logic [7:0] ToTerm  = 8'(TIMEOUT - 1);

  bus_state_t  state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        stall_q, stall_d;
  logic        err_q, err_d;
  logic [3:0]  ws_sel;
  logic        to_clr, to_en, to_tc;

  assign ws_sel = is_hi_region(cpu_addr) ? WsHiCnt : WsLoCnt;

  // Timeout counter sits at zero outside ACCESS so every access starts fresh.
  assign to_clr = (state_q != StAccess);
  assign to_en  = (state_q == StAccess);

  bus_timeout_ctr u_timeout_ctr (
    .clk      (ph2),
    .rst      (reset),
    .clr      (to_clr),
    .load     (1'b0),
    .load_val (8'h00),
    .en       (to_en),
    .term     (ToTerm),
    .tc       (to_tc)
  );

  // Next-state, capture and completion logic.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        // Every idle edge launches a new access.
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
        we_d    = ~cpu_read_en;
        wait_d  = ws_sel;
        state_d = (ws_sel != 4'd0) ? StWait : StAccess;
      end
      StWait: begin
        wait_d = (wait_q != 4'd0) ? wait_q - 4'd1 : 4'd0;
        if (wait_q <= 4'd1) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Ack has priority over a timeout on the same edge.
        if (mem_ack) begin
          state_d = StResp;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else if (to_tc) begin
          state_d = StResp;
          err_d   = 1'b1;
          if (!we_q) begin
            rdata_d = BUS_ERR_DATA;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    stall_d = (state_d != StIdle);
  end

  // State and datapath registers.
  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      rdata_q <= 8'h00;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = (state_q == StAccess);
  assign cpu_stall = stall_q;
  assign cpu_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Scoreboard bench for mem_bus_if with default parameters (WS_LO=0, WS_HI=1, TIMEOUT=15).
module tb_mem_bus_if;

  logic        ph2 = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_read_en;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        bus_err;

  mem_bus_if dut (
    .ph2         (ph2),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_read_en (cpu_read_en),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .bus_err     (bus_err)
  );

  always #5 ph2 = ~ph2;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rd;
    int          ack_after;  // ACCESS cycle carrying the ack, 0 = never
    logic [7:0]  mrdata;
    logic        wait_pulse;
    int          stall;
    int          req;
    int          delay;
    logic [7:0]  rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    int          stall;
    int          req;
    int          delay;
    logic [7:0]  rdata;
    logic        err;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int         cfg_ack_after = 0;
  logic [7:0] cfg_rdata = 8'h00;
  logic       cfg_wait_pulse = 1'b0;

  function automatic vec_t mk(input logic [15:0] addr, input logic [7:0] wdata, input logic rd,
                              input int ack_after, input logic [7:0] mrdata, input logic wp,
                              input int stall, input int req, input int delay,
                              input logic [7:0] rdata, input logic err);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.rd = rd; v.ack_after = ack_after; v.mrdata = mrdata;
    v.wait_pulse = wp; v.stall = stall; v.req = req; v.delay = delay; v.rdata = rdata;
    v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v, input bit push);
    exp_t e;
    cpu_addr       = v.addr;
    cpu_wdata      = v.wdata;
    cpu_read_en    = v.rd;
    cfg_ack_after  = v.ack_after;
    cfg_rdata      = v.mrdata;
    cfg_wait_pulse = v.wait_pulse;
    if (push) begin
      e.addr = v.addr; e.wdata = v.wdata; e.we = ~v.rd; e.stall = v.stall; e.req = v.req;
      e.delay = v.delay; e.rdata = v.rdata; e.err = v.err;
      sb.push_back(e);
    end
  endtask

  // Waits (bounded) for a falling-edge sample with the core not stalled.
  task automatic wait_idle();
    int n = 0;
    @(negedge ph2);
    while (cpu_stall && n < 100) begin
      @(negedge ph2);
      n++;
    end
    if (cpu_stall) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: stall still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_stall"}, int'(cpu_stall), 0);
    check({tag, "_mem_req"}, int'(mem_req), 0);
    check({tag, "_mem_we"}, int'(mem_we), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    check({tag, "_cpu_rdata"}, int'(cpu_rdata), 0);
    check({tag, "_bus_err"}, int'(bus_err), 0);
  endtask

  // Memory model: ack on the configured ACCESS cycle, optional stray ack outside ACCESS.
  initial begin
    int acc_cnt;
    acc_cnt   = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'hEE;
    forever begin
      @(negedge ph2);
      if (mem_req) acc_cnt++;
      else acc_cnt = 0;
      if (mem_req && acc_cnt == cfg_ack_after) begin
        mem_ack   = 1'b1;
        mem_rdata = cfg_rdata;
      end else if (!mem_req && cpu_stall && cfg_wait_pulse) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
      end
    end
  end

  // Monitor: measures each transaction and checks it against the scoreboard when stall falls.
  initial begin
    int   stall_cnt, req_cnt, delay_cnt;
    exp_t e;
    stall_cnt = 0; req_cnt = 0; delay_cnt = 0;
    forever begin
      @(negedge ph2);
      if (reset) begin
        stall_cnt = 0; req_cnt = 0; delay_cnt = 0;
      end else if (cpu_stall) begin
        stall_cnt++;
        if (mem_req) req_cnt++;
        else if (req_cnt == 0) delay_cnt++;
      end else if (stall_cnt > 0) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_txn: addr 0x%0h completed, required no transaction", mem_addr);
        end else begin
          e = sb.pop_front();
          check("stall_cycles", stall_cnt, e.stall);
          check("req_cycles", req_cnt, e.req);
          check("req_delay", delay_cnt, e.delay);
          check("cpu_rdata", int'(cpu_rdata), int'(e.rdata));
          check("bus_err", int'(bus_err), int'(e.err));
          check("mem_addr", int'(mem_addr), int'(e.addr));
          check("mem_we", int'(mem_we), int'(e.we));
          check("mem_wdata", int'(mem_wdata), int'(e.wdata));
        end
        stall_cnt = 0; req_cnt = 0; delay_cnt = 0;
      end
    end
  end

  initial begin
    //            addr     wdata  rd ack mrdata wp stall req dly rdata  err
    vecs[0] = mk(16'h1234, 8'h11, 1, 1,  8'hA5, 0, 2,  1,  0, 8'hA5, 0);
    vecs[1] = mk(16'h9000, 8'h3C, 0, 3,  8'h00, 0, 5,  3,  1, 8'hA5, 0);
    vecs[2] = mk(16'h0300, 8'h22, 1, 15, 8'h42, 0, 16, 15, 0, 8'h42, 0);
    vecs[3] = mk(16'h0200, 8'h33, 1, 0,  8'h00, 0, 16, 15, 0, 8'hFF, 1);
    vecs[4] = mk(16'h8100, 8'h44, 1, 2,  8'h5A, 1, 4,  2,  1, 8'h5A, 1);
    vecs[5] = mk(16'h0010, 8'h99, 0, 1,  8'h00, 0, 2,  1,  0, 8'h5A, 1);
    vecs[6] = mk(16'hC000, 8'h55, 1, 1,  8'h81, 0, 3,  1,  1, 8'h81, 0);

    cpu_addr    = 16'h0000;
    cpu_wdata   = 8'h00;
    cpu_read_en = 1'b1;
    #1 reset = 1'b1;
    #2 check_reset_vals("init");

    @(negedge ph2);
    drive_vec(vecs[0], 1'b1);
    #2 reset = 1'b0;
    @(posedge ph2);

    for (int i = 1; i < 6; i++) begin
      wait_idle();
      drive_vec(vecs[i], 1'b1);
      @(posedge ph2);
    end

    // Reset between edges while a never-acked read is in ACCESS.
    wait_idle();
    drive_vec(mk(16'h0400, 8'h66, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0), 1'b0);
    @(posedge ph2);
    @(negedge ph2);
    check("req_before_reset", int'(mem_req), 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("midreset");
    @(negedge ph2);
    drive_vec(vecs[6], 1'b1);
    #2 reset = 1'b0;
    @(posedge ph2);

    wait_idle();
    @(negedge ph2);
    #1 check("scoreboard_left", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
